// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared pipeline definitions for the instruction-fetch controller.
package imem_fetch_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    // Value presented to F/D whenever no fetched instruction is being handed over
    localparam logic [XLEN-1:0] INSTR_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        HOLD    = 3'd3,
        DISCARD = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Instruction-memory request/response channel between fetch control and IMEM.
interface imem_fetch_ctrl_if;
    import imem_fetch_ctrl_pkg::*;

    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ready;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rvalid,
        output mem_rdata
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage controller: one outstanding IMEM request, redirect squash, F/D stall/bubble generation.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int unsigned CNT_EN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [XLEN-1:0]            PC_F,
    input  logic                       PCSrc_E,
    input  logic                       Stall_in,
    imem_fetch_ctrl_if.master          mem,
    output logic [XLEN-1:0]            Instr_F,
    output logic                       Fetch_Stall,
    output logic                       Fetch_Bubble,
    output logic [XLEN-1:0]            Stall_Cnt
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic            mem_req_c;
    logic            redirect;

    // A redirect is meaningless while the block is held in reset
    assign redirect = PCSrc_E & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            buf_q   <= INSTR_ZERO;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        mem_req_c   = 1'b0;
        Instr_F     = INSTR_ZERO;
        Fetch_Stall = ~redirect;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                mem_req_c = 1'b1;
                if (mem.mem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_rvalid) begin
                    if (redirect) begin
                        state_d = REQ;
                    end else begin
                        buf_d   = mem.mem_rdata;
                        state_d = HOLD;
                    end
                end else if (redirect) begin
                    state_d = DISCARD;
                end
            end
            HOLD: begin
                Instr_F     = buf_q;
                Fetch_Stall = 1'b0;
                if (redirect || !Stall_in) begin
                    state_d = REQ;
                end
            end
            DISCARD: begin
                // The stale beat is consumed even if another redirect lands on it
                if (mem.mem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem.mem_req   = mem_req_c;
    assign mem.mem_addr  = PC_F;
    assign Fetch_Bubble  = (Fetch_Stall & ~Stall_in) | redirect;

    if (CNT_EN != 0) begin : g_cnt
        sat_counter #(
            .WIDTH (XLEN)
        ) u_stall_cnt (
            .clk   (clk),
            .rst_n (rst),
            .en    (Fetch_Stall),
            .count (Stall_Cnt)
        );
    end else begin : g_no_cnt
        assign Stall_Cnt = '0;
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed vector bench for imem_fetch_ctrl: per-cycle table plus reset and saturation sequences.
module tb_imem_fetch_ctrl;
    import imem_fetch_ctrl_pkg::*;

    typedef struct {
        logic [31:0]  pc;
        logic         pcsrc;
        logic         stall;
        logic         ready;
        logic         rvalid;
        logic [31:0]  rdata;
        fetch_state_e st;
        logic         req;
        logic [31:0]  instr;
        logic         fs;
        logic         bub;
        logic [31:0]  cnt;
    } vec_t;

    localparam int unsigned NVEC = 26;

    logic        clk;
    logic        rst;
    logic [31:0] PC_F;
    logic        PCSrc_E;
    logic        Stall_in;
    logic [31:0] Instr_F;
    logic        Fetch_Stall;
    logic        Fetch_Bubble;
    logic [31:0] Stall_Cnt;

    int checks = 0;
    int errors = 0;

    vec_t tv [0:NVEC-1];

    imem_fetch_ctrl_if mem_if ();

    imem_fetch_ctrl #(.CNT_EN(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .PC_F         (PC_F),
        .PCSrc_E      (PCSrc_E),
        .Stall_in     (Stall_in),
        .mem          (mem_if),
        .Instr_F      (Instr_F),
        .Fetch_Stall  (Fetch_Stall),
        .Fetch_Bubble (Fetch_Bubble),
        .Stall_Cnt    (Stall_Cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [31:0] pc, input logic pcsrc, input logic stall,
                               input logic ready, input logic rvalid, input logic [31:0] rdata,
                               input fetch_state_e st, input logic req, input logic [31:0] instr,
                               input logic fs, input logic bub, input logic [31:0] cnt);
        vec_t r;
        r.pc = pc; r.pcsrc = pcsrc; r.stall = stall; r.ready = ready; r.rvalid = rvalid;
        r.rdata = rdata; r.st = st; r.req = req; r.instr = instr; r.fs = fs; r.bub = bub;
        r.cnt = cnt;
        return r;
    endfunction

    task automatic drive(input logic [31:0] pc, input logic pcsrc, input logic stall,
                         input logic ready, input logic rvalid, input logic [31:0] rdata);
        PC_F              = pc;
        PCSrc_E           = pcsrc;
        Stall_in          = stall;
        mem_if.mem_ready  = ready;
        mem_if.mem_rvalid = rvalid;
        mem_if.mem_rdata  = rdata;
    endtask

    initial begin
        //           pc     src stl rdy rv  rdata         state    req instr         fs bub cnt
        tv[0]  = v(32'h0,   0, 0, 1, 0, 32'h0,        IDLE,    0, 32'h0,        1, 1, 0);
        tv[1]  = v(32'h0,   0, 0, 1, 0, 32'h0,        REQ,     1, 32'h0,        1, 1, 1);
        tv[2]  = v(32'h0,   0, 0, 1, 1, 32'h00500093, WAIT,    0, 32'h0,        1, 1, 2);
        tv[3]  = v(32'h4,   0, 0, 0, 0, 32'h0,        HOLD,    0, 32'h00500093, 0, 0, 3);
        tv[4]  = v(32'h4,   0, 0, 0, 0, 32'h0,        REQ,     1, 32'h0,        1, 1, 3);
        tv[5]  = v(32'h4,   0, 0, 0, 0, 32'h0,        REQ,     1, 32'h0,        1, 1, 4);
        tv[6]  = v(32'h8,   0, 0, 0, 0, 32'h0,        REQ,     1, 32'h0,        1, 1, 5);
        tv[7]  = v(32'h8,   0, 0, 0, 0, 32'h0,        REQ,     1, 32'h0,        1, 1, 6);
        tv[8]  = v(32'h8,   0, 0, 1, 0, 32'h0,        REQ,     1, 32'h0,        1, 1, 7);
        tv[9]  = v(32'h8,   0, 0, 0, 1, 32'h00A00113, WAIT,    0, 32'h0,        1, 1, 8);
        tv[10] = v(32'hC,   0, 1, 0, 0, 32'h0,        HOLD,    0, 32'h00A00113, 0, 0, 9);
        tv[11] = v(32'hC,   0, 1, 0, 1, 32'hFFFFFFFF, HOLD,    0, 32'h00A00113, 0, 0, 9);
        tv[12] = v(32'hC,   0, 1, 0, 0, 32'h0,        HOLD,    0, 32'h00A00113, 0, 0, 9);
        tv[13] = v(32'hC,   0, 0, 0, 0, 32'h0,        HOLD,    0, 32'h00A00113, 0, 0, 9);
        tv[14] = v(32'hC,   0, 0, 1, 0, 32'h0,        REQ,     1, 32'h0,        1, 1, 9);
        tv[15] = v(32'h40,  1, 0, 0, 0, 32'h0,        WAIT,    0, 32'h0,        0, 1, 10);
        tv[16] = v(32'h40,  0, 0, 0, 0, 32'h0,        DISCARD, 0, 32'h0,        1, 1, 10);
        tv[17] = v(32'h40,  0, 0, 0, 1, 32'hDEADBEEF, DISCARD, 0, 32'h0,        1, 1, 11);
        tv[18] = v(32'h40,  0, 1, 0, 0, 32'h0,        REQ,     1, 32'h0,        1, 0, 12);
        tv[19] = v(32'h40,  0, 0, 1, 0, 32'h0,        REQ,     1, 32'h0,        1, 1, 13);
        tv[20] = v(32'h44,  0, 0, 0, 0, 32'h0,        WAIT,    0, 32'h0,        1, 1, 14);
        tv[21] = v(32'h44,  1, 0, 0, 1, 32'h12345678, WAIT,    0, 32'h0,        0, 1, 15);
        tv[22] = v(32'h80,  0, 0, 1, 0, 32'h0,        REQ,     1, 32'h0,        1, 1, 15);
        tv[23] = v(32'h80,  0, 0, 0, 1, 32'h00108093, WAIT,    0, 32'h0,        1, 1, 16);
        tv[24] = v(32'h84,  1, 1, 0, 0, 32'h0,        HOLD,    0, 32'h00108093, 0, 1, 17);
        tv[25] = v(32'h100, 0, 0, 0, 0, 32'h0,        REQ,     1, 32'h0,        1, 1, 17);

        // Reset state, including reset dominance over a redirect
        rst = 1'b0;
        drive(32'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk); #1;
        check("rst_state",  32'(dut.state_q),        32'(IDLE));
        check("rst_req",    32'(mem_if.mem_req),     32'h0);
        check("rst_addr",   mem_if.mem_addr,         32'h1234);
        check("rst_instr",  Instr_F,                 32'h0);
        check("rst_fstall", 32'(Fetch_Stall),        32'h1);
        check("rst_bubble", 32'(Fetch_Bubble),       32'h1);
        check("rst_cnt",    Stall_Cnt,               32'h0);
        drive(32'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        check("rst_fstall_src", 32'(Fetch_Stall),    32'h1);
        check("rst_bubble_stl", 32'(Fetch_Bubble),   32'h0);

        // Per-cycle vectors starting from the cycle reset is released
        for (int i = 0; i < int'(NVEC); i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b1;
            drive(tv[i].pc, tv[i].pcsrc, tv[i].stall, tv[i].ready, tv[i].rvalid, tv[i].rdata);
            #1;
            check($sformatf("r%0d_state", i),  32'(dut.state_q),    32'(tv[i].st));
            check($sformatf("r%0d_req", i),    32'(mem_if.mem_req), 32'(tv[i].req));
            check($sformatf("r%0d_addr", i),   mem_if.mem_addr,     tv[i].pc);
            check($sformatf("r%0d_instr", i),  Instr_F,             tv[i].instr);
            check($sformatf("r%0d_fstall", i), 32'(Fetch_Stall),    32'(tv[i].fs));
            check($sformatf("r%0d_bubble", i), 32'(Fetch_Bubble),   32'(tv[i].bub));
            check($sformatf("r%0d_cnt", i),    Stall_Cnt,           tv[i].cnt);
        end

        // Reset asserted in WAIT while a response is arriving
        @(negedge clk);
        drive(32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive(32'h100, 1'b1, 1'b1, 1'b0, 1'b1, 32'hBAD0BAD0);
        check("mid_wait_state", 32'(dut.state_q), 32'(WAIT));
        rst = 1'b0;
        #1;
        check("mid_rst_state",  32'(dut.state_q),    32'(IDLE));
        check("mid_rst_req",    32'(mem_if.mem_req), 32'h0);
        check("mid_rst_addr",   mem_if.mem_addr,     32'h100);
        check("mid_rst_instr",  Instr_F,             32'h0);
        check("mid_rst_fstall", 32'(Fetch_Stall),    32'h1);
        check("mid_rst_bubble", 32'(Fetch_Bubble),   32'h0);
        check("mid_rst_cnt",    Stall_Cnt,           32'h0);
        Stall_in = 1'b0;
        #1;
        check("mid_rst_bubble2", 32'(Fetch_Bubble),  32'h1);
        @(negedge clk);
        rst = 1'b1;
        drive(32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD0BAD0);
        #1;
        check("post_rst_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk);
        #1;
        check("post_rst_state2", 32'(dut.state_q),    32'(REQ));
        check("post_rst_instr",  Instr_F,             32'h0);
        check("post_rst_req",    32'(mem_if.mem_req), 32'h1);
        @(negedge clk);
        mem_if.mem_rvalid = 1'b0;
        #1;
        check("post_rst_state3", 32'(dut.state_q), 32'(REQ));
        check("post_rst_cnt",    Stall_Cnt,        32'h2);

        // Saturation of the stall counter while stalled in REQ
        force dut.g_cnt.u_stall_cnt.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.g_cnt.u_stall_cnt.count_q;
        #1;
        check("sat_preload", Stall_Cnt, 32'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("sat_fstall%0d", k), 32'(Fetch_Stall), 32'h1);
            check($sformatf("sat_cnt%0d", k),    Stall_Cnt,        32'hFFFF_FFFF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset, declared first: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-low reset.
REQ-002 The block SHALL expose the following inputs:
- PC_F  in  32  current fetch PC from the PC register.
- PCSrc_E  in  1  branch/jump redirect taken in Execute.
- Stall_in  in  1  hazard-unit stall (load-use) for F/D.
- mem_ready  in  1  instruction memory accepts the request this cycle.
- mem_rvalid  in  1  instruction memory returns data this cycle.
- mem_rdata  in  32  returned instruction word.
REQ-003 The block SHALL expose the following outputs:
- mem_req  out  1  request valid.
- mem_addr  out  32  request byte address.
- Instr_F  out  32  instruction for the F/D register.
- Fetch_Stall  out  1  hold PC and F/D register.
- Fetch_Bubble  out  1  flush F/D register.
- Stall_Cnt  out  32  fetch-stall cycle counter.
REQ-004 The block SHALL have one parameter: CNT_EN, default 1, meaning Stall_Cnt is implemented (0 ties it to zero).

Function
REQ-005 The block SHALL implement states IDLE, REQ, WAIT, HOLD and DISCARD.
REQ-006 IDLE SHALL be entered on reset and SHALL go unconditionally to REQ on the first clock after rst deasserts.
REQ-007 REQ SHALL drive mem_req=1 and mem_addr=PC_F.
- mem_ready=1: go to WAIT.
- mem_ready=0: stay in REQ, with mem_addr tracking PC_F.
REQ-008 WAIT SHALL drive mem_req=0.
- mem_rvalid=1 and PCSrc_E=0: capture mem_rdata into buf and go to HOLD.
- mem_rvalid=1 and PCSrc_E=1: drop the data and go to REQ.
- mem_rvalid=0 and PCSrc_E=1: go to DISCARD.
- Otherwise: stay in WAIT.
REQ-009 DISCARD SHALL drop the first mem_rvalid beat and then go to REQ; PCSrc_E while in DISCARD SHALL keep the state in DISCARD.
REQ-010 HOLD SHALL drive Instr_F=buf.
- PCSrc_E=1: drop buf and go to REQ.
- Stall_in=0: go to REQ (instruction consumed).
- Stall_in=1: stay in HOLD.
REQ-011 Fetch_Stall SHALL be 0 in HOLD and in any cycle with PCSrc_E=1, and SHALL be 1 otherwise, so that a redirect always updates the PC.
REQ-012 Fetch_Bubble SHALL equal (Fetch_Stall & ~Stall_in) | PCSrc_E.
REQ-013 Instr_F SHALL equal buf in HOLD and 32'h0 in all other states.
REQ-014 The minimum fetch latency SHALL be 3 cycles per instruction (REQ, WAIT, HOLD) with a zero-wait memory.
REQ-015 Stall_Cnt SHALL increment by 1 on every cycle with Fetch_Stall=1 and SHALL saturate at 32'hFFFF_FFFF without wrapping.
REQ-016 mem_rvalid outside WAIT or DISCARD SHALL be ignored.
REQ-017 At most one request SHALL be outstanding at any time.

Reset
REQ-018 While rst=0, the following SHALL hold:
- state=IDLE, buf=32'h0, Stall_Cnt=0.
- mem_req=0, mem_addr=PC_F.
- Instr_F=0, Fetch_Stall=1, Fetch_Bubble=~Stall_in.
REQ-019 Reset asserted mid-transaction SHALL abandon any outstanding request, and any rvalid that arrives after reset release SHALL be ignored per REQ-016.

Structure
REQ-020 The state encoding type and the NOP/zero-instruction constant SHALL live in the shared pipeline package.
REQ-021 The saturating Stall_Cnt counter SHALL be a sub-module named sat_counter; all other logic SHALL be a single always block for state and buf plus combinational output decode.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Zero-wait memory with mem_ready=1 and rvalid one cycle after acceptance, PC_F=0x0, rdata=0x00500093 -> Instr_F=0x00500093 in the third cycle after reset release, with Fetch_Stall=0 in that cycle only.
- mem_ready held 0 for 4 cycles -> mem_req stays 1, Fetch_Stall=1 and Fetch_Bubble=1 throughout, and Stall_Cnt increases by at least 4.
- PCSrc_E=1 in WAIT, then rvalid two cycles later with rdata=0xDEADBEEF -> Fetch_Stall=0 in the PCSrc_E cycle, state goes to DISCARD, 0xDEADBEEF never appears on Instr_F, and the next mem_addr equals the new PC_F.
- In HOLD with Stall_in=1 for 3 cycles -> Instr_F held stable, Fetch_Stall=0 and Fetch_Bubble=0, no new mem_req; after Stall_in falls, state goes to REQ.
- Reset asserted in WAIT with a pending rvalid -> outputs take REQ-018 values immediately, and the rvalid is ignored.
- Stall_Cnt forced near 32'hFFFF_FFFE with 3 stall cycles -> Stall_Cnt ends at 32'hFFFF_FFFF.
